// File: rtl/router_pkg.sv
// Shared router types: flit format and per-VC state, plus default geometry constants.
package router_pkg;

    localparam int unsigned DEFAULT_NUM_VCS   = 3;
    localparam int unsigned DEFAULT_NUM_PORTS = 3;
    localparam int unsigned DEFAULT_DATA_W    = 32;
    localparam int unsigned PORT_W            = $clog2(DEFAULT_NUM_PORTS);

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t              ftype;
        logic [PORT_W-1:0]       dest;
        logic [DEFAULT_DATA_W-1:0] payload;
    } flit_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } vc_state_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with one-hot grant; priority moves past the grantee only when advanced.
module round_robin_arbiter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] req_i,
    input  logic             adv_i,
    output logic [Width-1:0] gnt_o
);

    localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1;

    logic [IdxW-1:0] ptr_q, ptr_d, gnt_idx;
    logic            found;
    int unsigned     idx;

    always_comb begin
        gnt_o   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < Width; i++) begin
            idx = (32'(ptr_q) + i) % Width;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx    = IdxW'(idx);
            end
        end
        ptr_d = ptr_q;
        if (adv_i && found) begin
            ptr_d = (gnt_idx == IdxW'(Width - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// Router input port: per-VC flit FIFOs with route/state tracking, one switch-allocator
// request row, and registered flit/credit outputs on grant.
module input_port_unit #(
    parameter int unsigned NUM_VCS   = router_pkg::DEFAULT_NUM_VCS,
    parameter int unsigned NUM_PORTS = router_pkg::DEFAULT_NUM_PORTS,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DATA_W    = router_pkg::DEFAULT_DATA_W,
    localparam int unsigned VcW      = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int unsigned PortW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flit_in_valid,
    input  logic [VcW-1:0]       flit_in_vc,
    input  router_pkg::flit_t    flit_in,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic [NUM_PORTS-1:0] req_out,
    input  logic [NUM_PORTS-1:0] grant_in,
    output logic                 flit_out_valid,
    output router_pkg::flit_t    flit_out,
    output logic [VcW-1:0]       flit_out_vc,
    output logic [PortW-1:0]     flit_out_port,
    output logic                 credit_out_valid,
    output logic [VcW-1:0]       credit_out_vc,
    output logic                 overflow_err
);
    import router_pkg::*;

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned FlitW = 2 + PortW + DATA_W;

    logic [FlitW-1:0] mem_q [NUM_VCS][DEPTH];
    logic [PtrW-1:0]  rd_ptr_q [NUM_VCS];
    logic [PtrW-1:0]  wr_ptr_q [NUM_VCS];
    logic [CntW-1:0]  cnt_q [NUM_VCS];
    vc_state_t        state_q [NUM_VCS];
    logic [PortW-1:0] route_q [NUM_VCS];

    logic             hold_valid_q, hold_valid_d;
    logic [VcW-1:0]   hold_vc_q, hold_vc_d;

    flit_t            head [NUM_VCS];
    logic [PortW-1:0] route [NUM_VCS];
    logic [NUM_VCS-1:0] elig, arb_req, sel, wr_en, deq;
    logic [VcW-1:0]   sel_idx;
    logic             sel_valid, held_ok, fire, ovf;

    always_comb begin
        elig = '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            head[v] = flit_t'(mem_q[v][rd_ptr_q[v]]);
            // BODY/TAIL at the head of an idle VC is a protocol error and falls back to port 0.
            if (state_q[v] == ACTIVE) begin
                route[v] = route_q[v];
            end else if (head[v].ftype == HEAD || head[v].ftype == HEADTAIL) begin
                route[v] = head[v].dest;
            end else begin
                route[v] = '0;
            end
            elig[v] = (cnt_q[v] != '0) && (32'(route[v]) < NUM_PORTS) && out_ready[route[v]];
        end

        // A held selection is kept until granted, unless its output port stops being ready.
        held_ok = hold_valid_q && elig[hold_vc_q];
        arb_req = held_ok ? (NUM_VCS'(1) << hold_vc_q) : elig;

        sel_valid = |sel;
        sel_idx   = '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (sel[v]) sel_idx = VcW'(v);
        end
        req_out = sel_valid ? (NUM_PORTS'(1) << route[sel_idx]) : '0;
        fire    = |(grant_in & req_out);

        ovf = 1'b0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            deq[v]   = fire && (sel_idx == VcW'(v));
            wr_en[v] = 1'b0;
            if (flit_in_valid && (32'(flit_in_vc) == v)) begin
                // A dequeue in the same cycle frees the slot, so a full VC can still accept.
                if (cnt_q[v] != CntW'(DEPTH) || deq[v]) wr_en[v] = 1'b1;
                else ovf = 1'b1;
            end
        end

        hold_valid_d = 1'b0;
        hold_vc_d    = hold_vc_q;
        if (!fire && sel_valid) begin
            hold_valid_d = 1'b1;
            hold_vc_d    = sel_idx;
        end
    end

    round_robin_arbiter #(
        .Width (NUM_VCS)
    ) u_vc_arb (
        .clk_i  (clk),
        .rst_ni (reset),
        .req_i  (arb_req),
        .adv_i  (fire),
        .gnt_o  (sel)
    );

    always_ff @(posedge clk) begin
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= flit_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                rd_ptr_q[v] <= '0;
                wr_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
                state_q[v]  <= IDLE;
                route_q[v]  <= '0;
            end
            hold_valid_q     <= 1'b0;
            hold_vc_q        <= '0;
            flit_out_valid   <= 1'b0;
            flit_out         <= '0;
            flit_out_vc      <= '0;
            flit_out_port    <= '0;
            credit_out_valid <= 1'b0;
            credit_out_vc    <= '0;
            overflow_err     <= 1'b0;
        end else begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
                if (wr_en[v] && !deq[v]) cnt_q[v] <= cnt_q[v] + 1'b1;
                else if (!wr_en[v] && deq[v]) cnt_q[v] <= cnt_q[v] - 1'b1;
                if (deq[v]) begin
                    rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
                    if (state_q[v] == IDLE) begin
                        if (head[v].ftype == HEAD) begin
                            state_q[v] <= ACTIVE;
                            route_q[v] <= head[v].dest;
                        end
                    end else if (head[v].ftype == TAIL) begin
                        state_q[v] <= IDLE;
                    end
                end
            end
            hold_valid_q     <= hold_valid_d;
            hold_vc_q        <= hold_vc_d;
            flit_out_valid   <= fire;
            credit_out_valid <= fire;
            if (fire) begin
                flit_out      <= head[sel_idx];
                flit_out_vc   <= sel_idx;
                flit_out_port <= route[sel_idx];
                credit_out_vc <= sel_idx;
            end
            if (ovf) overflow_err <= 1'b1;
        end
    end

endmodule
